ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only when a start is accepted.
REQ-004 opdata1_i  input  32  dividend, driven from the EX-stage reg1 operand; sampled only when a start is accepted.
REQ-005 opdata2_i  input  32  divisor, driven from the EX-stage reg2 operand; sampled only when a start is accepted.
REQ-006 start_i  input  1  division request; EX holds it high until it sees ready_o.
REQ-007 annul_i  input  1  abort request from flush/exception; overrides start_i.
REQ-008 result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 ready_o  output  1  result_o is valid.

Function
REQ-010 The block SHALL use four states: FREE, BYZERO, ON, END.
REQ-011 FREE, start_i=1, annul_i=0, opdata2_i=0: next state SHALL be BYZERO.
REQ-012 FREE, start_i=1, annul_i=0, opdata2_i!=0: the block SHALL latch the operands and signs, clear the 6-bit iteration counter to 0, and go to ON.
REQ-013 FREE with start_i=0 or annul_i=1: the block SHALL stay in FREE with ready_o=0 and result_o=0.
REQ-014 Signed operands (signed_div_i=1): the block SHALL divide the two's-complement magnitudes of the operands.
REQ-015 ON, annul_i=0, counter<32: each cycle SHALL perform one restoring step.
  - Trial-subtract the divisor from the partial remainder, shifted left one bit.
  - Shift the quotient bit in: 1 if the subtraction is non-negative, else 0.
  - Increment the counter.
REQ-016 ON, counter=32: the block SHALL apply sign fixup and go to END.
  - Quotient is negated when signed and the operand signs differ.
  - Remainder is negated when signed and the dividend is negative.
REQ-017 ON, annul_i=1: the block SHALL go to FREE on the next edge, discard all partial state, and keep ready_o=0.
REQ-018 BYZERO: the block SHALL go to END with quotient=0 and remainder=0.
REQ-019 END: result_o and ready_o SHALL be registered outputs.
  - result_o = {remainder, quotient}, ready_o=1.
  - Both are held while start_i=1.
  - When start_i=0, the next edge SHALL give FREE, ready_o=0, result_o=0.
REQ-020 Latency: with edge 0 being the edge that accepts start_i, ready_o SHALL first read 1 after edge 34 for a non-zero divisor and after edge 2 for a zero divisor.
REQ-021 start_i is ignored in ON, BYZERO and END; operand changes after acceptance SHALL NOT affect the result.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-023 annul_i=1 in BYZERO or END SHALL force FREE on the next edge with ready_o=0 and result_o=0.

Reset
REQ-024 rst=1 at a rising edge SHALL force state FREE, counter 0, ready_o=0 and result_o=0, including in the middle of a division.
REQ-025 rst SHALL take priority over annul_i and start_i.

Configuration
REQ-026 The macro DIV_SIGNED_EN SHALL select signed support.
  - Defined: signed_div_i is honoured per REQ-014, REQ-016 and REQ-022.
  - Undefined: signed_div_i is ignored, every division is unsigned, and no sign-fixup logic is built.

Verification
REQ-027 Unsigned 100 / 7, start held: ready_o=1 after edge 34, result_o = {0x00000002, 0x0000000E}.
REQ-028 Signed 0xFFFFFFF9 (-7) / 2 (with DIV_SIGNED_EN): result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
  - Without DIV_SIGNED_EN, the same operands give {0x00000001, 0x7FFFFFFC}.
REQ-029 0x12345678 / 0: ready_o=1 after edge 2, result_o = 0.
REQ-030 Start 100 / 7, annul_i=1 at edge 10: FREE after edge 11; ready_o stays 0 through edge 40.
  - A new start of 9 / 3 then gives {0, 3} after a further 34 edges.
REQ-031 rst=1 at edge 20 of a division: ready_o=0 and result_o=0 after edge 20; the block returns to FREE and accepts a new start.
REQ-032 In END with start_i held for 5 extra cycles: result_o is stable and ready_o=1.
  - Dropping start_i gives ready_o=0 on the next edge.

Source files
------------

// File: rtl/ex_div.sv
// ex_div -- 32-bit iterative restoring divider for the EX stage.
//
// Purpose:
//   Divides opdata1_i by opdata2_i and returns {remainder, quotient}.
//   A non-zero divisor needs one accept cycle, 32 shift/subtract cycles,
//   one fixup cycle and one output-register cycle. A zero divisor takes a
//   short path that returns all zeros.
//
// Ports:
//   clk           in   1  clock, rising edge
//   rst           in   1  synchronous active-high reset
//   signed_div_i  in   1  1 = signed divide, 0 = unsigned (sampled on accept)
//   opdata1_i     in  32  dividend (sampled on accept)
//   opdata2_i     in  32  divisor  (sampled on accept)
//   start_i       in   1  request, held by EX until ready_o
//   annul_i       in   1  abort, overrides start_i
//   result_o      out 64  {remainder[63:32], quotient[31:0]}, registered
//   ready_o       out  1  result_o valid, registered
//
// Configuration macro:
//   DIV_SIGNED_EN  defined   -> signed_div_i honoured, sign fixup built
//                  undefined -> every division is unsigned

module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_BYZERO = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;     // partial remainder
  logic [31:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [31:0] dvsr_q, dvsr_d;   // divisor magnitude
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] trial_s;          // remainder shifted left with next dividend bit
  logic [32:0] diff_s;           // trial minus divisor; bit 32 set means negative

`ifdef DIV_SIGNED_EN
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  // Two's-complement magnitude of an operand when dividing signed.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      magnitude = 32'd0 - v;
    end else begin
      magnitude = v;
    end
  endfunction
`else
  // signed_div_i has no effect in the unsigned-only build.
  logic unused_signed_s;
  assign unused_signed_s = signed_div_i;
`endif

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    trial_s = {rem_q, quo_q[31]};
    diff_s  = trial_s - {1'b0, dvsr_q};
  end

  // Next-state and datapath control for the divider FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = 64'd0;
    ready_d  = 1'b0;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif

    case (state_q)
      ST_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d = ST_ON;
            cnt_d   = 6'd0;
            rem_d   = 32'd0;
`ifdef DIV_SIGNED_EN
            quo_d     = magnitude(opdata1_i, signed_div_i);
            dvsr_d    = magnitude(opdata2_i, signed_div_i);
            neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d = signed_div_i && opdata1_i[31];
`else
            quo_d  = opdata1_i;
            dvsr_d = opdata2_i;
`endif
          end
        end else begin
          state_d = ST_FREE;
        end
      end

      ST_ON: begin
        if (annul_i) begin
          state_d = ST_FREE;
          cnt_d   = 6'd0;
          rem_d   = 32'd0;
          quo_d   = 32'd0;
          dvsr_d  = 32'd0;
        end else if (cnt_q == 6'd32) begin
          // All 32 quotient bits are in; restore the result signs.
          state_d = ST_END;
          cnt_d   = 6'd0;
`ifdef DIV_SIGNED_EN
          if (neg_quo_q) begin
            quo_d = 32'd0 - quo_q;
          end else begin
            quo_d = quo_q;
          end
          if (neg_rem_q) begin
            rem_d = 32'd0 - rem_q;
          end else begin
            rem_d = rem_q;
          end
`endif
        end else begin
          if (!diff_s[32]) begin
            rem_d = diff_s[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = trial_s[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end

      ST_BYZERO: begin
        if (annul_i) begin
          state_d = ST_FREE;
        end else begin
          state_d = ST_END;
          rem_d   = 32'd0;
          quo_d   = 32'd0;
        end
      end

      ST_END: begin
        if (annul_i) begin
          state_d = ST_FREE;
        end else if (start_i) begin
          // Hold the result until EX drops its request.
          state_d  = ST_END;
          result_d = {rem_q, quo_q};
          ready_d  = 1'b1;
        end else begin
          state_d = ST_FREE;
        end
      end

      default: begin
        state_d = ST_FREE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FREE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div -- self-checking bench for ex_div.
// Table-driven vectors plus hand-written sequences for annul, reset and hold.
// Expected results go into a scoreboard queue when a division is started and
// are popped when ready_o rises.

module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks;
  int n_fail;

  logic [63:0] sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model built on the language's own division operators.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    logic signed [31:0] sa;
    logic signed [31:0] sb_v;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa   = a;
      sb_v = b;
      q = sa / sb_v;
      r = sa % sb_v;
      return {r, q};
    end
`else
    sa   = 32'sd0;
    sb_v = 32'sd0;
    if (sgn && sa == sb_v) begin
      q = 32'd0;
    end
`endif
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  // Wait for ready_o, then check latency and the scoreboard head.
  task automatic wait_ready(input string name, input int exp_lat, output logic [63:0] got_res);
    bit got;
    int lat;
    logic [63:0] exp;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (ready_o === 1'b1) begin
        got = 1'b1;
        lat = n;
        break;
      end
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 64'd0;
    got_res = result_o;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: ready_o never rose, expected after edge %0d", name, exp_lat);
    end else begin
      check_int({name, "_latency"}, lat, exp_lat);
      check64({name, "_result"}, result_o, exp);
    end
  endtask

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int lat, input int hold);
    logic [63:0] res;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    sb.push_back(exp);
    tick();
    // Operand changes after acceptance must not matter.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(1, 0));
    wait_ready(name, lat, res);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_int({name, "_hold_ready"}, int'(ready_o), 1);
      check64({name, "_hold_result"}, result_o, res);
    end
    start_i = 1'b0;
    tick();
    check_int({name, "_drop_ready"}, int'(ready_o), 0);
    check64({name, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic [63:0] res;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          bad;

    n_checks = 0;
    n_fail   = 0;

    tbl[0]  = '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 34};
    tbl[1]  = '{32'h1234_5678,  32'd0,          1'b0, 64'h0,                  2};
    tbl[2]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 64'h00000000_FFFFFFFF, 34};
    tbl[3]  = '{32'd5,          32'd10,         1'b0, 64'h00000005_00000000, 34};
    tbl[4]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'h00000000_00000001, 34};
    tbl[5]  = '{32'd9,          32'd3,          1'b0, 64'h00000000_00000003, 34};
    tbl[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 64'h80000000_00000000, 34};
`ifdef DIV_SIGNED_EN
    tbl[7]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 34};
    tbl[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000, 34};
    tbl[9]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 64'h00000001_FFFFFFFD, 34};
    tbl[10] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 64'hFFFFFFFE_0000000E, 34};
`else
    tbl[7]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 64'h00000001_7FFFFFFC, 34};
    tbl[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h80000000_00000000, 34};
    tbl[9]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 64'h00000007_00000000, 34};
    tbl[10] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 64'hFFFFFF9C_00000000, 34};
`endif

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check_int("reset_ready", int'(ready_o), 0);
    check64("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();
    check_int("idle_ready", int'(ready_o), 0);

    // start with annul in FREE is not accepted
    opdata1_i = 32'd5;
    opdata2_i = 32'd1;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (ready_o !== 1'b0 || result_o !== 64'd0) bad++;
    end
    check_int("free_annul_quiet", bad, 0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].exp, tbl[i].lat, 0);
    end

    // result held while start stays high, then released
    run_div("hold", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 5);

    for (int k = 0; k < 12; k++) begin
      ra = $urandom;
      rb = (k % 3 == 0) ? 32'($urandom_range(16, 1)) : $urandom;
      if (k % 4 == 1) rb = 32'd0 - rb;
      rs = 1'($urandom_range(1, 0));
      run_div($sformatf("rnd%0d", k), ra, rb, rs, model(ra, rb, rs), (rb == 32'd0) ? 2 : 34, 0);
    end

    // annul during ON
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check_int("annul_on_ready", int'(ready_o), 0);
    check64("annul_on_result", result_o, 64'd0);
    bad = 0;
    for (int e = 12; e <= 40; e++) begin
      tick();
      if (ready_o !== 1'b0) bad++;
    end
    check_int("annul_on_quiet", bad, 0);
    run_div("after_annul", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 34, 0);

    // reset in the middle of a division
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();
    repeat (19) tick();
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    check_int("midrst_ready", int'(ready_o), 0);
    check64("midrst_result", result_o, 64'd0);
    bad = 0;
    repeat (20) begin
      tick();
      if (ready_o !== 1'b0) bad++;
    end
    check_int("midrst_quiet", bad, 0);
    run_div("after_rst", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 0);

    // annul in BYZERO
    opdata1_i = 32'h1234_5678;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (ready_o !== 1'b0 || result_o !== 64'd0) bad++;
    end
    check_int("annul_byzero_quiet", bad, 0);

    // annul in END while start is still held
    opdata1_i = 32'd50;
    opdata2_i = 32'd6;
    start_i   = 1'b1;
    sb.push_back(64'h00000002_00000008);
    tick();
    wait_ready("end_annul", 34, res);
    annul_i = 1'b1;
    tick();
    check_int("annul_end_ready", int'(ready_o), 0);
    check64("annul_end_result", result_o, 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    check_int("annul_end_idle", int'(ready_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
